// File: rtl/multi_start_driver.sv
// Initiator side of a start/done multi-cycle handshake. It accepts one operand, starts the
// attached unit, waits for done (or a timeout), and returns the result over a response port.
module multi_start_driver #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic             unit_start,
    output logic [WIDTH-1:0] unit_inp,
    input  logic             unit_done,
    input  logic [WIDTH-1:0] unit_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_timeout,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] unit_inp_q, unit_inp_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Ready/valid are decoded from state only, so neither depends combinationally on the peer.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        unit_inp_d    = unit_inp_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    unit_inp_d = req_data;
                    state_d    = START;
                end
            end
            START: begin
                // A done seen here belongs to no operation of ours, so it is ignored.
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (unit_done) begin
                    rsp_data_d    = unit_out;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (wait_cnt_q == LAST_CNT) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            unit_inp_q    <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            unit_inp_q    <= unit_inp_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign unit_start  = (state_q == START);
    assign rsp_valid   = (state_q == RESP);
    assign unit_inp    = unit_inp_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_multi_start_driver.sv
// Directed bench for multi_start_driver: normal, backpressure, timeout, boundary,
// reset mid-operation and back-to-back requests, with MAX_WAIT = 4.
module tb_multi_start_driver;

    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_data = '0;
    logic             unit_start;
    logic [WIDTH-1:0] unit_inp;
    logic             unit_done = 1'b0;
    logic [WIDTH-1:0] unit_out = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_timeout;
    logic [1:0]       dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int start_base;

    multi_start_driver #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .unit_start (unit_start),
        .unit_inp   (unit_inp),
        .unit_done  (unit_done),
        .unit_out   (unit_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .dbg_state  (dbg_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) start_cnt <= 0;
        else if (unit_start) start_cnt <= start_cnt + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation. done_idx = WAIT cycle (1..MAX_WAIT) in which done is raised, 0 = never.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] data, input int done_idx,
                         input logic [WIDTH-1:0] out, input logic start_done, input int backp,
                         input logic keep_valid, input logic [WIDTH-1:0] next_data);
        logic [WIDTH-1:0] exp_data;
        logic             exp_to;
        exp_to   = (done_idx == 0);
        exp_data = exp_to ? '0 : out;

        req_valid = 1'b1;
        req_data  = data;
        step();
        chk({tag, "_start"}, unit_start, 1);
        chk({tag, "_start_inp"}, unit_inp, data);
        chk({tag, "_start_rdy"}, req_ready, 0);
        chk({tag, "_start_rv"}, rsp_valid, 0);
        req_valid = keep_valid;
        req_data  = keep_valid ? next_data : data;
        unit_done = start_done;
        unit_out  = start_done ? 32'hBAD0_0000 : '0;

        for (int i = 1; i <= MAX_WAIT; i++) begin
            step();
            chk({tag, "_wait_start"}, unit_start, 0);
            chk({tag, "_wait_inp"}, unit_inp, data);
            chk({tag, "_wait_rdy"}, req_ready, 0);
            chk({tag, "_wait_rv"}, rsp_valid, 0);
            unit_done = (i == done_idx);
            unit_out  = (i == done_idx) ? out : 32'hFFFF_FFFF;
            if (i == done_idx) break;
        end

        rsp_ready = (backp == 0);
        step();
        unit_done = 1'b0;
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_rsp_data"}, rsp_data, exp_data);
        chk({tag, "_rsp_to"}, rsp_timeout, exp_to);
        chk({tag, "_rsp_rdy"}, req_ready, 0);

        for (int j = 1; j < backp; j++) begin
            unit_done = 1'b1;
            unit_out  = 32'h0BAD_0BAD;
            step();
            chk({tag, "_hold_valid"}, rsp_valid, 1);
            chk({tag, "_hold_data"}, rsp_data, exp_data);
            chk({tag, "_hold_to"}, rsp_timeout, exp_to);
            chk({tag, "_hold_rdy"}, req_ready, 0);
            chk({tag, "_hold_inp"}, unit_inp, data);
        end
        unit_done = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk({tag, "_idle_rv"}, rsp_valid, 0);
        chk({tag, "_idle_rdy"}, req_ready, 1);
        chk({tag, "_idle_start"}, unit_start, 0);
        chk({tag, "_idle_inp"}, unit_inp, data);
        chk({tag, "_idle_data"}, rsp_data, exp_data);
        req_valid = keep_valid;
        req_data  = next_data;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_start", unit_start, 0);
        chk("rst_inp", unit_inp, 0);
        chk("rst_rv", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_to", rsp_timeout, 0);
        chk("rst_state", dbg_state, 0);
        reset = 1'b0;
        #1;
        chk("rst_rdy", req_ready, 1);
        step();

        do_op("normal", 32'h0000_1234, 3, 32'h0000_2468, 1'b0, 0, 1'b0, '0);
        do_op("bp", 32'h0000_1234, 3, 32'h0000_2468, 1'b0, 5, 1'b1, 32'h0000_5555);
        do_op("bp_next", 32'h0000_5555, 1, 32'h0000_AAAA, 1'b0, 0, 1'b0, '0);
        do_op("timeout", 32'h0000_0077, 0, 32'h0000_0099, 1'b0, 0, 1'b0, '0);
        do_op("start_done", 32'h0000_0088, 0, '0, 1'b1, 0, 1'b0, '0);
        do_op("boundary", 32'h0000_0042, 4, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, '0);

        req_valid = 1'b1;
        req_data  = 32'h0000_CAFE;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("mid_state_wait", dbg_state, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_start", unit_start, 0);
        chk("mid_rst_rv", rsp_valid, 0);
        chk("mid_rst_inp", unit_inp, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_to", rsp_timeout, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rel_rdy", req_ready, 1);
        step();
        chk("mid_idle_rdy", req_ready, 1);
        chk("mid_idle_start", unit_start, 0);
        do_op("after_rst", 32'h0000_0010, 2, 32'h0000_0020, 1'b0, 0, 1'b0, '0);

        start_base = start_cnt;
        do_op("b2b_1", 32'h1, 2, 32'h2, 1'b0, 0, 1'b1, 32'h2);
        do_op("b2b_2", 32'h2, 2, 32'h4, 1'b0, 0, 1'b1, 32'h3);
        do_op("b2b_3", 32'h3, 2, 32'h6, 1'b0, 0, 1'b0, '0);
        step();
        chk("b2b_starts", 32'(start_cnt - start_base), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_start_driver.md
Name: multi_start_driver

Overview:
- Initiator side of the start/done multi-cycle handshake.
- Accepts one operand over a valid/ready request port, pulses `unit_start` to an attached multi-cycle unit and holds `unit_inp` stable. It then waits for `unit_done`, captures `unit_out` and returns the result over a valid/ready response port.
- Includes a wait-cycle timeout so a stuck unit cannot hang the pipeline. Sits between a sequencing controller and any multi-cycle compute unit or composite of such units.

Parameters:
- WIDTH, 32, operand and result width in bits.
- MAX_WAIT, 15, maximum number of WAIT cycles before timeout (legal range >= 1).
- CNT_W, $clog2(MAX_WAIT+1), wait counter width (derived, not overridden).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request operand valid.
- req_ready  output  1  driver can accept a request.
- req_data  input  WIDTH  request operand.
- unit_start  output  1  one-cycle start pulse to the unit.
- unit_inp  output  WIDTH  operand to the unit; held constant for the whole operation.
- unit_done  input  1  unit completion strobe.
- unit_out  input  WIDTH  unit result; valid when unit_done is high.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  captured result; 0 on timeout.
- rsp_timeout  output  1  response is a timeout, not a result.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; wait_cnt = 0.
  - unit_start = 0, unit_inp = 0, rsp_valid = 0, rsp_data = 0, rsp_timeout = 0.
  - req_ready = 1 as soon as reset deasserts.
- State machine: IDLE, START, WAIT, RESP. All outputs are registered or decoded from state only; no combinational input-to-output paths.
- IDLE:
  - req_ready = 1.
  - On req_valid at an edge: unit_inp <= req_data, go to START. No other action.
- START:
  - unit_start = 1 for exactly this one cycle; req_ready = 0.
  - unit_done is ignored in this cycle (it cannot belong to this op).
  - wait_cnt <= 0; go to WAIT.
- WAIT:
  - unit_start = 0; unit_inp held.
  - If unit_done = 1: rsp_data <= unit_out, rsp_timeout <= 0, go to RESP.
  - Else if wait_cnt == MAX_WAIT-1: rsp_data <= 0, rsp_timeout <= 1, go to RESP.
  - Else wait_cnt <= wait_cnt + 1.
  - unit_done in the last allowed cycle wins over timeout.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_timeout held stable until handshake.
  - On rsp_ready = 1: go to IDLE. rsp_valid drops the next cycle.
  - rsp_data and rsp_timeout keep their last value in IDLE; they are don't-care when rsp_valid = 0.
  - unit_done pulses while in RESP or IDLE are ignored.
- Latency:
  - Request handshake at edge 0 -> unit_start high in cycle 1.
  - First WAIT cycle is cycle 2.
  - unit_done sampled in cycle k -> rsp_valid high from cycle k+1.
  - Minimum request-to-response latency is 3 cycles.
- Throughput: one operation in flight. req_ready = 0 from START through RESP, so back-to-back requests are separated by at least one IDLE cycle.
- unit_inp changes only on an IDLE request handshake.
- Reset mid-operation aborts the op and discards any pending result. The attached unit is reset by the same signal.

Test Plan:
- Normal op: reset, req_data = 0x0000_1234 with req_valid for 1 cycle; unit model asserts done 3 cycles after start with unit_out = 0x0000_2468 -> unit_start high exactly 1 cycle; unit_inp = 0x1234 throughout; rsp_valid with rsp_data = 0x2468, rsp_timeout = 0, 1 cycle after done.
- Backpressure: same op with rsp_ready low for 5 cycles -> rsp_valid, rsp_data and rsp_timeout stable for all 5 cycles; req_ready stays 0; a second req_valid is not accepted until after the response handshake plus 1 IDLE cycle.
- Timeout: MAX_WAIT = 4, unit never asserts done -> exactly 4 WAIT cycles, then rsp_valid with rsp_data = 0, rsp_timeout = 1.
- Boundary: MAX_WAIT = 4, done in the 4th WAIT cycle with unit_out = 0xDEAD_BEEF -> rsp_data = 0xDEADBEEF, rsp_timeout = 0. Done asserted during the START cycle only -> ignored, leading to timeout.
- Reset mid-op: assert reset asynchronously in the 2nd WAIT cycle (between edges) -> unit_start, rsp_valid, unit_inp and rsp_data all 0 immediately; after release, req_ready = 1 and a fresh op completes normally.
- Back-to-back: 3 requests 0x1, 0x2, 0x3 with req_valid held high and unit latency 2 -> 3 responses in order with the correct results and exactly 3 unit_start pulses.
